// File: rtl/samp_rr_arbiter.sv
// ---------------------------------------------------------------------------
// samp_rr_arbiter
//
// Round-robin scheduler that shares one downstream I/Q pipeline among NREQ
// sample FIFOs. One source at a time is granted for a burst of at most
// BURST pulls. Each pull captures that FIFO's head sample into a registered
// valid/ready output stage, tagged with the source index.
//
// State table:
//   state | meaning
//   IDLE  | arbitration cycle, no pull; pick next eligible source from ptr
//   GRANT | source gnt owns the pipeline; pull while it has data and room
//
// Ports:
//   Clk        in   clock, rising edge
//   Reset      in   asynchronous, active-high clear
//   ReqEmpty   in   [NREQ]    per-FIFO empty flag
//   ReqI/ReqQ  in   [NREQ*W]  per-FIFO head sample, slice k = [k*W +: W]
//   ReqEnable  in   [NREQ]    per-source arbitration enable
//   ReqPull    out  [NREQ]    one-hot-or-zero pull strobe (combinational)
//   OutValid   out            output stage holds a sample
//   OutI/OutQ  out  [W]       output sample
//   OutSrc     out  [SW]      source index of the output sample
//   OutReady   in             downstream accepts when OutValid && OutReady
//   Busy       out            a grant is active
// ---------------------------------------------------------------------------
module samp_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int W     = 24,
    parameter int BURST = 4
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [NREQ-1:0]           ReqEmpty,
    input  logic [NREQ*W-1:0]         ReqI,
    input  logic [NREQ*W-1:0]         ReqQ,
    input  logic [NREQ-1:0]           ReqEnable,
    output logic [NREQ-1:0]           ReqPull,
    output logic                      OutValid,
    output logic [W-1:0]              OutI,
    output logic [W-1:0]              OutQ,
    output logic [$clog2(NREQ)-1:0]   OutSrc,
    input  logic                      OutReady,
    output logic                      Busy
);

    localparam int SW = $clog2(NREQ);
    localparam int CW = $clog2(BURST) + 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [SW-1:0]   r_gnt, w_gnt_nxt;
    logic [SW-1:0]   r_ptr, w_ptr_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            r_out_valid, w_out_valid_nxt;
    logic [W-1:0]    r_out_i, w_out_i_nxt;
    logic [W-1:0]    r_out_q, w_out_q_nxt;
    logic [SW-1:0]   r_out_src, w_out_src_nxt;

    logic [NREQ-1:0] w_elig;
    logic            w_any;
    logic [SW-1:0]   w_pick;
    logic [SW-1:0]   w_gnt_inc;
    logic            w_gnt_en;
    logic            w_gnt_empty;
    logic            w_gnt_ok;
    logic            w_pull;
    logic [W-1:0]    w_din_i;
    logic [W-1:0]    w_din_q;

    assign w_elig    = ReqEnable & ~ReqEmpty;
    assign w_any     = |w_elig;
    assign w_gnt_inc = (r_gnt == SW'(NREQ - 1)) ? '0 : r_gnt + 1'b1;

    // Rotating priority: among eligible sources take the one with the
    // smallest forward distance from ptr.
    always_comb begin
        int best_d;
        int d;
        best_d = NREQ;
        d      = 0;
        w_pick = '0;
        for (int k = 0; k < NREQ; k++) begin
            d = (k + NREQ - int'(r_ptr)) % NREQ;
            if (w_elig[k] && (d < best_d)) begin
                best_d = d;
                w_pick = SW'(k);
            end
        end
    end

    // Granted-source mux, written as a compare loop so every select is
    // by constant index.
    always_comb begin
        w_gnt_en    = 1'b0;
        w_gnt_empty = 1'b1;
        w_din_i     = '0;
        w_din_q     = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (r_gnt == SW'(k)) begin
                w_gnt_en    = ReqEnable[k];
                w_gnt_empty = ReqEmpty[k];
                w_din_i     = ReqI[k*W +: W];
                w_din_q     = ReqQ[k*W +: W];
            end
        end
    end

    assign w_gnt_ok = w_gnt_en && !w_gnt_empty;
    // The FIFOs do not guard against underflow, so pull only with data present.
    assign w_pull   = (r_state == ST_GRANT) && w_gnt_ok && (!r_out_valid || OutReady);

    always_comb begin
        ReqPull = '0;
        for (int k = 0; k < NREQ; k++) begin
            ReqPull[k] = w_pull && (r_gnt == SW'(k));
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_cnt_nxt       = r_cnt;
        w_ptr_nxt       = r_ptr;
        w_out_valid_nxt = r_out_valid;
        w_out_i_nxt     = r_out_i;
        w_out_q_nxt     = r_out_q;
        w_out_src_nxt   = r_out_src;

        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_GRANT;
                    w_gnt_nxt   = w_pick;
                    w_cnt_nxt   = '0;
                end
            end
            ST_GRANT: begin
                if (!w_gnt_ok) begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = w_gnt_inc;
                end else if (w_pull) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == CW'(BURST - 1)) begin
                        w_state_nxt = ST_IDLE;
                        w_ptr_nxt   = w_gnt_inc;
                    end
                end
                // else stalled: hold with cnt frozen
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A pull overrides an accept, giving a bubble-free handoff.
        if (w_pull) begin
            w_out_valid_nxt = 1'b1;
            w_out_i_nxt     = w_din_i;
            w_out_q_nxt     = w_din_q;
            w_out_src_nxt   = r_gnt;
        end else if (r_out_valid && OutReady) begin
            w_out_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_i     <= '0;
            r_out_q     <= '0;
            r_out_src   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_ptr       <= w_ptr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_i     <= w_out_i_nxt;
            r_out_q     <= w_out_q_nxt;
            r_out_src   <= w_out_src_nxt;
        end
    end

    assign OutValid = r_out_valid;
    assign OutI     = r_out_i;
    assign OutQ     = r_out_q;
    assign OutSrc   = r_out_src;
    assign Busy     = (r_state == ST_GRANT);

endmodule

// File: tb/tb_samp_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_samp_rr_arbiter
//
// Self-checking bench for samp_rr_arbiter. Source FIFOs are modelled as
// arrays; the expected output stream is built transaction-by-transaction
// from the round-robin rules (first eligible from ptr, up to BURST samples,
// ptr moves past the served source).
// ---------------------------------------------------------------------------
module tb_samp_rr_arbiter;

    localparam int NREQ  = 4;
    localparam int W     = 24;
    localparam int BURST = 4;
    localparam int SW    = $clog2(NREQ);
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [SW-1:0] src;
        logic [W-1:0]  i;
        logic [W-1:0]  q;
    } samp_t;

    logic                 Clk = 1'b0;
    logic                 Reset;
    logic [NREQ-1:0]      ReqEmpty;
    logic [NREQ*W-1:0]    ReqI;
    logic [NREQ*W-1:0]    ReqQ;
    logic [NREQ-1:0]      ReqEnable;
    logic [NREQ-1:0]      ReqPull;
    logic                 OutValid;
    logic [W-1:0]         OutI;
    logic [W-1:0]         OutQ;
    logic [SW-1:0]        OutSrc;
    logic                 OutReady;
    logic                 Busy;

    samp_rr_arbiter #(.NREQ(NREQ), .W(W), .BURST(BURST)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .ReqEmpty  (ReqEmpty),
        .ReqI      (ReqI),
        .ReqQ      (ReqQ),
        .ReqEnable (ReqEnable),
        .ReqPull   (ReqPull),
        .OutValid  (OutValid),
        .OutI      (OutI),
        .OutQ      (OutQ),
        .OutSrc    (OutSrc),
        .OutReady  (OutReady),
        .Busy      (Busy)
    );

    always #5 Clk = ~Clk;

    logic [W-1:0]    fi [NREQ][DEPTH];
    logic [W-1:0]    fq [NREQ][DEPTH];
    int              fcnt [NREQ];
    samp_t           exp_q [$];
    int              m_ptr;
    int              n_err;
    int              n_chk;
    logic [NREQ-1:0] pend;

    always_comb begin
        ReqEmpty = '1;
        ReqI     = '0;
        ReqQ     = '0;
        for (int k = 0; k < NREQ; k++) begin
            ReqEmpty[k]    = (fcnt[k] == 0);
            ReqI[k*W +: W] = fi[k][0];
            ReqQ[k*W +: W] = fq[k][0];
        end
    end

    task automatic push_fifo(input int k, input logic [W-1:0] i, input logic [W-1:0] q);
        fi[k][fcnt[k]] = i;
        fq[k][fcnt[k]] = q;
        fcnt[k]++;
    endtask

    task automatic pop_fifo(input int k);
        for (int j = 0; j < DEPTH - 1; j++) begin
            fi[k][j] = fi[k][j+1];
            fq[k][j] = fq[k][j+1];
        end
        fcnt[k]--;
    endtask

    task automatic clear_fifos();
        for (int k = 0; k < NREQ; k++) fcnt[k] = 0;
    endtask

    // Advance to the next falling edge; pulls seen before the rising edge
    // pop the FIFO model.
    task automatic tick();
        pend = ReqPull;
        @(negedge Clk);
        for (int k = 0; k < NREQ; k++)
            if (pend[k] && fcnt[k] > 0) pop_fifo(k);
    endtask

    task automatic build_expected(input logic [NREQ-1:0] en);
        int rd [NREQ];
        int pick;
        int n;
        for (int k = 0; k < NREQ; k++) rd[k] = 0;
        forever begin
            pick = -1;
            for (int i = NREQ - 1; i >= 0; i--) begin
                int k;
                k = (m_ptr + i) % NREQ;
                if (en[k] && rd[k] < fcnt[k]) pick = k;
            end
            if (pick < 0) break;
            n = 0;
            while (n < BURST && rd[pick] < fcnt[pick]) begin
                exp_q.push_back(samp_t'({SW'(pick), fi[pick][rd[pick]], fq[pick][rd[pick]]}));
                rd[pick]++;
                n++;
            end
            m_ptr = (pick + 1) % NREQ;
        end
    endtask

    // Runs the DUT until the expected stream is consumed and the block is
    // idle, checking the pull and output-stage rules every cycle.
    task automatic run_traffic(input string name, input int budget, input bit rand_ready);
        bit    stall_prev;
        bit    done;
        samp_t held;
        samp_t got;
        samp_t e;
        stall_prev = 1'b0;
        done       = 1'b0;
        held       = '0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            OutReady = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            got = samp_t'({OutSrc, OutI, OutQ});
            n_chk++;
            if (!$onehot0(ReqPull)) begin
                n_err++;
                $display("FAIL %s pull_onehot: got %b required at most one bit", name, ReqPull);
            end
            for (int k = 0; k < NREQ; k++) begin
                if (ReqPull[k]) begin
                    n_chk++;
                    if (fcnt[k] == 0 || !ReqEnable[k]) begin
                        n_err++;
                        $display("FAIL %s pull_illegal: src %0d pulled with count %0d enable %b", name, k, fcnt[k], ReqEnable[k]);
                    end
                end
            end
            if (stall_prev) begin
                n_chk++;
                if (OutValid !== 1'b1 || got !== held) begin
                    n_err++;
                    $display("FAIL %s stall_hold: got valid=%b %h required valid=1 %h", name, OutValid, got, held);
                end
            end
            if (OutValid && !OutReady) begin
                n_chk++;
                if (ReqPull !== '0) begin
                    n_err++;
                    $display("FAIL %s stall_pull: got %b required 0", name, ReqPull);
                end
                stall_prev = 1'b1;
                held       = got;
            end else begin
                stall_prev = 1'b0;
            end
            if (OutValid && OutReady) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL %s extra_sample: got %h required none", name, got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_err++;
                        $display("FAIL %s sample: got src=%0d i=%h q=%h required src=%0d i=%h q=%h",
                                 name, got.src, got.i, got.q, e.src, e.i, e.q);
                    end
                end
            end
            if (exp_q.size() == 0 && !Busy && !OutValid) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        n_chk++;
        if (!done) begin
            n_err++;
            $display("FAIL %s timeout: %0d samples still expected busy=%b", name, exp_q.size(), Busy);
            exp_q.delete();
        end
        for (int k = 0; k < NREQ; k++) begin
            if (ReqEnable[k]) begin
                n_chk++;
                if (fcnt[k] != 0) begin
                    n_err++;
                    $display("FAIL %s leftover: src %0d has %0d required 0", name, k, fcnt[k]);
                end
            end
        end
    endtask

    task automatic test_reset();
        Reset     = 1'b1;
        OutReady  = 1'b0;
        ReqEnable = '1;
        clear_fifos();
        @(negedge Clk);
        @(negedge Clk);
        for (int k = 0; k < NREQ; k++) push_fifo(k, W'($urandom), W'($urandom));
        tick();
        #1;
        n_chk++;
        if ({OutValid, OutI, OutQ, OutSrc, Busy, ReqPull} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got valid=%b i=%h q=%h src=%0d busy=%b pull=%b required all 0",
                     OutValid, OutI, OutQ, OutSrc, Busy, ReqPull);
        end
        clear_fifos();
        @(negedge Clk);
        Reset = 1'b0;
        m_ptr = 0;
    endtask

    // Three samples in FIFO 0: pulls in cycles 1-3, outputs after edges 2-4.
    task automatic test_single_source();
        for (int n = 1; n <= 3; n++) push_fifo(0, W'(n), W'(-n));
        tick();
        for (int c = 1; c <= 5; c++) begin
            OutReady = 1'b1;
            #1;
            n_chk++;
            if (ReqPull !== ((c <= 3) ? 4'b0001 : 4'b0000)) begin
                n_err++;
                $display("FAIL single_pull c%0d: got %b", c, ReqPull);
            end
            n_chk++;
            if (OutValid !== (c >= 2 && c <= 4) || Busy !== (c <= 4)) begin
                n_err++;
                $display("FAIL single_valid_busy c%0d: got valid=%b busy=%b", c, OutValid, Busy);
            end
            if (c >= 2 && c <= 4) begin
                n_chk++;
                if (OutI !== W'(c - 1) || OutQ !== W'(-(c - 1)) || OutSrc !== SW'(0)) begin
                    n_err++;
                    $display("FAIL single_data c%0d: got i=%h q=%h src=%0d required i=%h q=%h src=0",
                             c, OutI, OutQ, OutSrc, W'(c - 1), W'(-(c - 1)));
                end
            end
            tick();
        end
        m_ptr = 1;
    endtask

    // Full FIFOs, OutReady held high: one sample per cycle plus one
    // arbitration bubble per burst.
    task automatic test_round_robin();
        int    j;
        samp_t e;
        for (int k = 0; k < NREQ; k++)
            for (int n = 0; n < BURST; n++) push_fifo(k, W'($urandom), W'($urandom));
        build_expected('1);
        j = 0;
        tick();
        for (int c = 1; c < 200 && j < NREQ * BURST; c++) begin
            OutReady = 1'b1;
            #1;
            for (int k = 0; k < NREQ; k++) begin
                if (ReqPull[k]) begin
                    n_chk++;
                    if (fcnt[k] == 0) begin
                        n_err++;
                        $display("FAIL rr_pull_empty: src %0d c%0d", k, c);
                    end
                end
            end
            if (OutValid) begin
                e = exp_q.pop_front();
                n_chk++;
                if (samp_t'({OutSrc, OutI, OutQ}) !== e) begin
                    n_err++;
                    $display("FAIL rr_sample %0d: got src=%0d i=%h required src=%0d i=%h", j, OutSrc, OutI, e.src, e.i);
                end
                n_chk++;
                if (c != 2 + j + j / BURST) begin
                    n_err++;
                    $display("FAIL rr_timing %0d: got cycle %0d required %0d", j, c, 2 + j + j / BURST);
                end
                j++;
            end
            tick();
        end
        n_chk++;
        if (j != NREQ * BURST) begin
            n_err++;
            $display("FAIL rr_count: got %0d required %0d", j, NREQ * BURST);
        end
        exp_q.delete();
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        for (int it = 0; it < 4; it++) begin
            for (int k = 0; k < NREQ; k++)
                for (int n = $urandom_range(1, 4); n > 0; n--) push_fifo(k, W'($urandom), W'($urandom));
            build_expected('1);
            run_traffic("backpressure", 400, 1'b1);
        end
    endtask

    task automatic test_enable_mask();
        ReqEnable = 4'b1010;
        for (int k = 0; k < NREQ; k++)
            for (int n = 0; n < 4; n++) push_fifo(k, W'($urandom), W'($urandom));
        build_expected(ReqEnable);
        run_traffic("enable_mask", 200, 1'b0);
        clear_fifos();
        ReqEnable = '1;
    endtask

    task automatic test_random_mix();
        for (int it = 0; it < 8; it++) begin
            ReqEnable = NREQ'($urandom);
            for (int k = 0; k < NREQ; k++)
                for (int n = $urandom_range(0, 4); n > 0; n--) push_fifo(k, W'($urandom), W'($urandom));
            build_expected(ReqEnable);
            run_traffic("random_mix", 400, 1'b1);
            clear_fifos();
            ReqEnable = '1;
        end
    endtask

    task automatic test_mid_burst_disable();
        int              g;
        samp_t           s0;
        logic [NREQ-1:0] one_g;
        g = m_ptr;
        for (int k = 0; k < NREQ; k++)
            for (int n = 0; n < 2; n++) push_fifo(k, W'($urandom), W'($urandom));
        s0       = samp_t'({SW'(g), fi[g][0], fq[g][0]});
        one_g    = '0;
        one_g[g] = 1'b1;
        tick();
        OutReady = 1'b1;
        #1;
        n_chk++;
        if (ReqPull !== one_g) begin
            n_err++;
            $display("FAIL disable_first_pull: got %b required %b", ReqPull, one_g);
        end
        tick();
        ReqEnable[g] = 1'b0;
        exp_q.push_back(s0);
        m_ptr = (g + 1) % NREQ;
        build_expected(ReqEnable);
        run_traffic("mid_disable", 200, 1'b0);
        n_chk++;
        if (fcnt[g] != 1) begin
            n_err++;
            $display("FAIL disable_remaining: src %0d has %0d required 1", g, fcnt[g]);
        end
        clear_fifos();
        ReqEnable = '1;
    endtask

    task automatic test_reset_mid_burst();
        int g;
        g = m_ptr;
        for (int n = 0; n < 4; n++) push_fifo(g, W'($urandom), W'($urandom));
        tick();
        OutReady = 1'b1;
        #1;
        tick();
        OutReady = 1'b1;
        #1;
        n_chk++;
        if (OutValid !== 1'b1 || Busy !== 1'b1) begin
            n_err++;
            $display("FAIL rst_pre: got valid=%b busy=%b required 1 1", OutValid, Busy);
        end
        #2;
        Reset = 1'b1;
        #1;
        n_chk++;
        if ({OutValid, OutI, OutQ, OutSrc, Busy, ReqPull} !== '0) begin
            n_err++;
            $display("FAIL rst_async: got valid=%b i=%h q=%h src=%0d busy=%b pull=%b required all 0",
                     OutValid, OutI, OutQ, OutSrc, Busy, ReqPull);
        end
        @(negedge Clk);
        Reset = 1'b0;
        n_chk++;
        if (fcnt[g] != 3) begin
            n_err++;
            $display("FAIL rst_fifo: src %0d has %0d required 3", g, fcnt[g]);
        end
        for (int k = 0; k < NREQ; k++)
            if (k != g) push_fifo(k, W'($urandom), W'($urandom));
        m_ptr = 0;
        exp_q.delete();
        build_expected('1);
        run_traffic("after_reset", 200, 1'b1);
    endtask

    initial begin
        n_err = 0;
        n_chk = 0;
        m_ptr = 0;
        pend  = '0;
        for (int k = 0; k < NREQ; k++) begin
            fcnt[k] = 0;
            for (int j = 0; j < DEPTH; j++) begin
                fi[k][j] = '0;
                fq[k][j] = '0;
            end
        end
        test_reset();
        test_single_source();
        test_round_robin();
        test_backpressure();
        test_enable_mask();
        test_mid_burst_disable();
        test_random_mix();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
